axi4_burst_master: RTL and testbench
====================================

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; one of 32, 64 or 128.
REQ-003 SHALL have parameter IWIDTH, default 1, AXI ID width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_write, input, 1, 1 = burst write, 0 = burst read.
REQ-010 SHALL have port cmd_addr, input, AWIDTH, byte address of first beat.
REQ-011 SHALL have port cmd_len, input, 8, beats minus one (AXI len encoding).
REQ-012 SHALL have port wr_data, input, DWIDTH, write beat data.
REQ-013 SHALL have port wr_valid, input, 1, write beat offered.
REQ-014 SHALL have port wr_ready, output, 1, write beat consumed.
REQ-015 SHALL have port rd_data, output, DWIDTH, read beat data.
REQ-016 SHALL have port rd_valid, output, 1, read beat offered.
REQ-017 SHALL have port rd_last, output, 1, final beat of the read burst.
REQ-018 SHALL have port rd_ready, input, 1, read beat consumed.
REQ-019 SHALL have port done, output, 1, one-cycle pulse at command completion.
REQ-020 SHALL have port err, output, 1, valid with done; 1 = any non-OKAY response or rejected command.
REQ-021 SHALL have port m, axi4_ifc (AWIDTH, DWIDTH, IWIDTH), initiator end: drives aw*, w*, bready, ar*, rready; samples awready, wready, b*, arready, r*.

Function
REQ-022 SHALL run FSM states IDLE, AW, W, B, AR, R; cmd_ready = 1 only in IDLE.
REQ-023 On accept, SHALL latch addr with low log2(DWIDTH/8) bits forced to 0, and latch len; next state AW (write) or AR (read).
REQ-024 On accept where aligned addr[11:0] + (len+1)*DWIDTH/8 > 4096, SHALL issue no AXI traffic, pulse done with err=1 next cycle, and return to IDLE.
REQ-025 SHALL drive constant fields: id 0, size log2(DWIDTH/8), burst INCR (2'b01), lock 0, cache 4'b0011, prot 3'b000, qos 0, region 0, wstrb all ones.
REQ-026 In AW, awvalid SHALL be 1 with addr and len stable until awready; on handshake, go to W.
REQ-027 In W, SHALL drive wvalid = wr_valid, wdata = wr_data, wr_ready = wready, combinationally; no W beat before AW handshake.
REQ-028 SHALL count W beats with 8-bit counter cleared on accept; wlast = 1 iff counter == len; after the last handshake, go to B.
REQ-029 In B, bready SHALL be 1; on bvalid, err = (bresp != 0), done pulses the same cycle as the handshake, and state returns to IDLE.
REQ-030 In AR, arvalid SHALL be 1 with stable fields until arready, then go to R.
REQ-031 In R, SHALL drive rd_valid = rvalid, rd_data = rdata, rd_last = rlast, rready = rd_ready, combinationally.
REQ-032 In R, SHALL OR-accumulate (rresp != 0) across beats; on the rlast handshake, pulse done with err = accumulated value and go to IDLE.
REQ-033 Outside W, wr_ready and wvalid SHALL be 0; outside R, rd_valid and rready SHALL be 0.
REQ-034 Len 0 (single beat) SHALL assert wlast on the first W beat.
REQ-035 Back-to-back commands SHALL be supported: a new command may be accepted the cycle after done.
REQ-036 A valid deasserting upstream or stalling downstream SHALL only stall the FSM, never drop or duplicate a beat.

Reset
REQ-037 While reset is high, state SHALL be IDLE and awvalid, wvalid, bready, arvalid, rready, done, err, wr_ready and rd_valid SHALL be 0; cmd_ready SHALL be 0 during reset and 1 the first cycle after.
REQ-038 Reset mid-burst SHALL abandon the transaction with no completion; system-level reset of the responder is required.

Verification
REQ-039 Write addr 0x100, len 3, data 1..4, responder awready after 2 cycles -> one AW (len 3, INCR), 4 W beats with wlast on beat 4, done=1 err=0.
REQ-040 Read addr 0x200, len 7, rd_ready toggling 1/0 -> 8 beats delivered in order, rd_last on beat 8 only, done with err=0.
REQ-041 Write addr 0xFF8, len 3, DWIDTH 32 (crosses 4 KB) -> no awvalid, done=1 err=1 one cycle after accept.
REQ-042 Read len 2 with rresp SLVERR on beat 2 -> all 3 beats delivered, done err=1.
REQ-043 Write len 0, bresp DECERR -> single beat with wlast, done err=1.
REQ-044 Reset asserted during W of a len 15 write -> next cycle all valids 0, state IDLE, no done; a subsequent command completes normally.

Source files
------------

// File: rtl/axi4_burst_master_if.sv
// AXI4 full-channel bundle shared by the burst master and its responder.
// No logic and no latency; each channel carries its own valid/ready pair.
// Backpressure is per channel, driven by whichever end owns the ready signal.
interface axi4_ifc #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1
);
    logic [IWIDTH-1:0]   awid;
    logic [AWIDTH-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awvalid;
    logic                awready;

    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [IWIDTH-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [IWIDTH-1:0]   arid;
    logic [AWIDTH-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                arvalid;
    logic                arready;

    logic [IWIDTH-1:0]   rid;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport initiator (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport responder (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master driven by a simple command port.
// Data beats pass through combinationally; done pulses with the B / last-R handshake.
// Upstream/downstream stalls only hold the FSM; 4 KB-crossing commands are rejected.
module axi4_burst_master #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              done,
    output logic              err,
    axi4_ifc.initiator        m
);
    localparam int BYTES = DWIDTH / 8;
    localparam int LSB   = $clog2(BYTES);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic              r_rerr;
    logic              r_rej;

    logic [AWIDTH-1:0] w_addr_al;
    logic [13:0]       w_span;
    logic              w_cross;
    logic              w_accept;
    logic              w_w_hs;
    logic              w_r_hs;
    logic              w_unused_ok;

    assign w_addr_al = {cmd_addr[AWIDTH-1:LSB], {LSB{1'b0}}};
    // Offset within the 4 KB page plus burst byte count; the sum fits in 14 bits.
    assign w_span    = {2'b00, w_addr_al[11:0]} + ((14'(cmd_len) + 14'd1) << LSB);
    assign w_cross   = (w_span > 14'd4096);

    assign m.awid     = '0;
    assign m.awaddr   = r_addr;
    assign m.awlen    = r_len;
    assign m.awsize   = 3'(LSB);
    assign m.awburst  = 2'b01;
    assign m.awlock   = 1'b0;
    assign m.awcache  = 4'b0011;
    assign m.awprot   = 3'b000;
    assign m.awqos    = 4'd0;
    assign m.awregion = 4'd0;
    assign m.wdata    = wr_data;
    assign m.wstrb    = '1;
    assign m.wlast    = (r_beat == r_len);
    assign m.arid     = '0;
    assign m.araddr   = r_addr;
    assign m.arlen    = r_len;
    assign m.arsize   = 3'(LSB);
    assign m.arburst  = 2'b01;
    assign m.arlock   = 1'b0;
    assign m.arcache  = 4'b0011;
    assign m.arprot   = 3'b000;
    assign m.arqos    = 4'd0;
    assign m.arregion = 4'd0;
    assign rd_data    = m.rdata;

    assign w_unused_ok = ^{m.bid, m.rid};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        w_accept  = 1'b0;
        w_w_hs    = 1'b0;
        w_r_hs    = 1'b0;
        m.awvalid = 1'b0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                w_accept  = cmd_valid;
                done      = r_rej;
                err       = r_rej;
                if (cmd_valid && !w_cross) begin
                    w_next = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                m.awvalid = 1'b1;
                if (m.awready) w_next = S_W;
            end
            S_W: begin
                m.wvalid = wr_valid;
                wr_ready = m.wready;
                w_w_hs   = wr_valid && m.wready;
                if (w_w_hs && m.wlast) w_next = S_B;
            end
            S_B: begin
                m.bready = 1'b1;
                if (m.bvalid) begin
                    done   = 1'b1;
                    err    = (m.bresp != 2'b00);
                    w_next = S_IDLE;
                end
            end
            S_AR: begin
                m.arvalid = 1'b1;
                if (m.arready) w_next = S_R;
            end
            S_R: begin
                rd_valid = m.rvalid;
                rd_last  = m.rlast;
                m.rready = rd_ready;
                w_r_hs   = m.rvalid && rd_ready;
                if (w_r_hs && m.rlast) begin
                    done   = 1'b1;
                    err    = r_rerr || (m.rresp != 2'b00);
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Reset silences every handshake output immediately, not just after the edge.
        if (reset) begin
            cmd_ready = 1'b0;
            w_accept  = 1'b0;
            w_w_hs    = 1'b0;
            w_r_hs    = 1'b0;
            m.awvalid = 1'b0;
            m.wvalid  = 1'b0;
            m.bready  = 1'b0;
            m.arvalid = 1'b0;
            m.rready  = 1'b0;
            wr_ready  = 1'b0;
            rd_valid  = 1'b0;
            rd_last   = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_rerr <= 1'b0;
            r_rej  <= 1'b0;
        end else begin
            r_rej <= w_accept && w_cross;
            if (w_accept) begin
                r_addr <= w_addr_al;
                r_len  <= cmd_len;
                r_beat <= '0;
                r_rerr <= 1'b0;
            end
            if (w_w_hs) r_beat <= r_beat + 8'd1;
            if (w_r_hs) r_rerr <= r_rerr || (m.rresp != 2'b00);
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomised scoreboard bench: a command driver pushes expected AXI/data/done events,
// an AXI responder model serves the bus, and a monitor pops and compares.
module tb_axi4_burst_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 1;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_valid, wr_ready, rd_valid, rd_last, rd_ready, done, err;

    always #5 clk = ~clk;

    axi4_ifc #(.AWIDTH(AW), .DWIDTH(DW), .IWIDTH(IW)) bus ();

    axi4_burst_master #(.AWIDTH(AW), .DWIDTH(DW), .IWIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .err(err), .m(bus)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ax_t;
    typedef struct { logic [DW-1:0] d; logic last; } beat_t;

    ax_t        exp_aw[$], exp_ar[$];
    beat_t      exp_w[$], exp_r[$];
    logic       exp_done[$];
    logic [1:0] plan_b[$], plan_r[$];

    int   checks = 0, failures = 0;
    logic aw_ok = 1'b0;
    logic rd_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] rmem(input logic [AW-1:0] a);
        logic [31:0] h;
        h = (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
        return {DW/32{h}};
    endfunction

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    initial begin
        ax_t   e;
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset) aw_ok = 1'b0;
            if (bus.awvalid && exp_aw.size() == 0) chk("unexpected_awvalid", 1, 0);
            if (bus.arvalid && exp_ar.size() == 0) chk("unexpected_arvalid", 1, 0);
            if (bus.awvalid && bus.awready && exp_aw.size() != 0) begin
                e = exp_aw.pop_front();
                chk("aw_addr", bus.awaddr, e.addr);
                chk("aw_len", bus.awlen, e.len);
                chk("aw_ctl", {bus.awsize, bus.awburst, bus.awcache}, {3'd2, 2'b01, 4'b0011});
                aw_ok = 1'b1;
            end
            if (bus.arvalid && bus.arready && exp_ar.size() != 0) begin
                e = exp_ar.pop_front();
                chk("ar_addr", bus.araddr, e.addr);
                chk("ar_len", bus.arlen, e.len);
                chk("ar_ctl", {bus.arsize, bus.arburst, bus.arcache}, {3'd2, 2'b01, 4'b0011});
            end
            if (bus.wvalid && !aw_ok) chk("w_before_aw", 1, 0);
            if (bus.wvalid && bus.wready) begin
                if (exp_w.size() == 0) chk("unexpected_w_beat", 1, 0);
                else begin
                    b = exp_w.pop_front();
                    chk("w_data", bus.wdata, b.d);
                    chk("w_last", bus.wlast, b.last);
                    chk("w_strb", bus.wstrb, {BYTES{1'b1}});
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) chk("unexpected_rd_beat", 1, 0);
                else begin
                    b = exp_r.pop_front();
                    chk("rd_data", rd_data, b.d);
                    chk("rd_last", rd_last, b.last);
                end
            end
            if (done) begin
                aw_ok = 1'b0;
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_err", err, exp_done.pop_front());
            end
        end
    end

    // AXI responder and downstream read sink.
    initial begin
        int            b_pend = 0, r_len = 0, r_beat = 0;
        logic          r_act = 1'b0, r_hs = 1'b0, b_hs = 1'b0;
        logic [AW-1:0] r_addr = '0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.bid = '0;
        bus.rvalid = 0; bus.rresp = 0; bus.rlast = 0; bus.rdata = '0; bus.rid = '0;
        rd_ready = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                b_pend = 0; r_act = 0; r_hs = 0; b_hs = 0;
            end else begin
                b_hs = bus.bvalid && bus.bready;
                r_hs = bus.rvalid && bus.rready;
                if (bus.wvalid && bus.wready && bus.wlast) b_pend++;
                if (b_hs) begin
                    b_pend--;
                    if (plan_b.size() != 0) void'(plan_b.pop_front());
                end
                if (r_hs) begin
                    if (plan_r.size() != 0) void'(plan_r.pop_front());
                    if (r_beat == r_len) r_act = 0;
                    r_beat++;
                end
                if (bus.arvalid && bus.arready) begin
                    r_act = 1; r_addr = bus.araddr; r_len = int'(bus.arlen); r_beat = 0;
                end
            end
            @(posedge clk); #1;
            bus.awready = 1'($urandom % 2);
            bus.wready  = ($urandom % 4) != 0;
            bus.arready = 1'($urandom % 2);
            rd_ready    = rd_toggle ? ~rd_ready : (($urandom % 3) != 0);
            if (b_hs || !bus.bvalid) begin
                bus.bvalid = (b_pend > 0) && (($urandom % 3) != 0);
                bus.bresp  = (plan_b.size() != 0) ? plan_b[0] : 2'b00;
            end
            if (r_hs || !bus.rvalid) begin
                bus.rvalid = r_act && (($urandom % 4) != 0);
                bus.rdata  = rmem(r_addr + AW'(r_beat * BYTES));
                bus.rlast  = (r_beat == r_len);
                bus.rresp  = (plan_r.size() != 0) ? plan_r[0] : 2'b00;
            end
            if (reset) begin
                bus.bvalid = 0; bus.rvalid = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag, input logic exp_cmd_ready);
        chk({tag, "_cmd_ready"}, cmd_ready, exp_cmd_ready);
        chk({tag, "_valids"}, {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready},
            5'b0);
        chk({tag, "_done_err"}, {done, err}, 2'b00);
        chk({tag, "_wr_rdy_rd_vld"}, {wr_ready, rd_valid}, 2'b00);
    endtask

    // rerr_beat: -1 none, -2 random per beat; rst_at: W beat index at which to reset, -1 none.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input int len,
                          input logic [1:0] bresp, input int rerr_beat,
                          input logic [1:0] rerr_val, input logic seq_data, input int rst_at);
        logic [AW-1:0] al;
        logic [DW-1:0] d[$];
        logic          rej, any_err;
        logic [1:0]    rr;
        int            idx, cyc;
        al  = addr & ~AW'(BYTES - 1);
        rej = (int'(al[11:0]) + (len + 1) * BYTES) > 4096;
        any_err = 1'b0;
        if (rej) exp_done.push_back(1'b1);
        else if (wr) begin
            exp_aw.push_back('{al, 8'(len)});
            for (int i = 0; i <= len; i++) begin
                d.push_back(seq_data ? DW'(i + 1) : DW'($urandom));
                exp_w.push_back('{d[i], i == len});
            end
            plan_b.push_back(bresp);
            exp_done.push_back(bresp != 2'b00);
        end else begin
            exp_ar.push_back('{al, 8'(len)});
            for (int i = 0; i <= len; i++) begin
                exp_r.push_back('{rmem(al + AW'(i * BYTES)), i == len});
                if (rerr_beat == -2) rr = (($urandom % 8) == 0) ? 2'(1 + $urandom % 3) : 2'b00;
                else rr = (i == rerr_beat) ? rerr_val : 2'b00;
                plan_r.push_back(rr);
                any_err |= (rr != 2'b00);
            end
            exp_done.push_back(any_err);
        end

        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cmd_ready && cyc < 200);
        if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;

        if (rej) begin
            @(negedge clk);
            chk("reject_done_err", {done, err}, 2'b11);
            chk("reject_no_axi", {bus.awvalid, bus.arvalid}, 2'b00);
        end else if (wr) begin
            idx = 0; cyc = 0;
            while (idx <= len && cyc < 3000) begin
                @(posedge clk); #1;
                if (idx == rst_at) begin
                    reset = 1;
                    exp_aw.delete(); exp_w.delete(); exp_done.delete(); plan_b.delete();
                    @(posedge clk);
                    @(negedge clk);
                    check_idle_outputs("in_reset", 1'b0);
                    @(posedge clk); #1;
                    reset = 0; wr_valid = 0;
                    @(negedge clk);
                    check_idle_outputs("after_reset", 1'b1);
                    return;
                end
                wr_valid = ($urandom % 4) != 0;
                wr_data  = d[idx];
                @(negedge clk);
                cyc++;
                if (wr_valid && wr_ready) idx++;
            end
            @(posedge clk); #1;
            wr_valid = 0;
        end

        cyc = 0;
        while (exp_done.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_done.size() != 0) begin
            chk("done_timeout", 0, 1);
            exp_done.delete();
        end
        chk("beats_left", exp_w.size() + exp_r.size(), 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        do_cmd(1, 32'h100, 3, 2'b00, -1, 2'b00, 1, -1);
        rd_toggle = 1;
        do_cmd(0, 32'h200, 7, 2'b00, -1, 2'b00, 0, -1);
        rd_toggle = 0;
        do_cmd(1, 32'hFF8, 3, 2'b00, -1, 2'b00, 0, -1);
        do_cmd(0, 32'h340, 2, 2'b00, 1, 2'b10, 0, -1);
        do_cmd(1, 32'h480, 0, 2'b11, -1, 2'b00, 0, -1);
        do_cmd(1, 32'h600, 15, 2'b00, -1, 2'b00, 0, 5);
        do_cmd(1, 32'h700, 5, 2'b00, -1, 2'b00, 0, -1);
        do_cmd(0, 32'hFFC, 0, 2'b00, -1, 2'b00, 0, -1);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if (($urandom % 3) == 0) a[11:0] = 12'hF00 + 12'($urandom % 256);
            do_cmd(1'($urandom % 2), a,
                   (($urandom % 8) == 0) ? int'($urandom % 256) : int'($urandom % 16),
                   (($urandom % 4) == 0) ? 2'(1 + $urandom % 3) : 2'b00,
                   -2, 2'b00, 0, -1);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
